// File: rtl/run_ctrl_pkg.sv
// Shared constants for the front-panel run/stop receiver.
// Holds the run/halt state encoding, its width, the synchronizer depth and
// the number of cycles spent in BOOT after reset release.
package run_ctrl_pkg;

    localparam int unsigned STATE_W     = 3;
    localparam int unsigned SYNC_DEPTH  = 2;
    localparam int unsigned BOOT_CYCLES = 2;

    localparam logic [STATE_W-1:0] BOOT   = 3'd0;
    localparam logic [STATE_W-1:0] RUN    = 3'd1;
    localparam logic [STATE_W-1:0] DRAIN  = 3'd2;
    localparam logic [STATE_W-1:0] HALTED = 3'd3;
    localparam logic [STATE_W-1:0] STEP   = 3'd4;

endpackage

// File: rtl/run_stop_ctrl_debounce.sv
// Synchronizer plus debouncer for one channel of front-panel inputs.
// The whole bus is a single channel: any bit change restarts the counter.
// Ports:
//   clock       - system clock
//   resetButton - asynchronous active-low reset
//   rawIn       - raw asynchronous input (WIDTH bits)
//   syncOut     - synchronized input (last synchronizer stage)
//   stableOut   - accepted (debounced) value, registered
//   changed     - high in the cycle before stableOut takes a new value
module debounce
    import run_ctrl_pkg::*;
#(
    parameter int unsigned      WIDTH     = 1,
    parameter int unsigned      CYCLES    = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             resetButton,
    input  logic [WIDTH-1:0] rawIn,
    output logic [WIDTH-1:0] syncOut,
    output logic [WIDTH-1:0] stableOut,
    output logic             changed
);

    localparam int unsigned CNT_W = $clog2(CYCLES + 1);

    logic [SYNC_DEPTH-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                 stable_q, stable_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;

    assign syncOut   = sync_q[SYNC_DEPTH-1];
    assign stableOut = stable_q;

    // Count consecutive cycles the synchronized value disagrees with the accepted one.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        changed  = 1'b0;
        if (syncOut != stable_q) begin
            if (cnt_q == CNT_W'(CYCLES - 1)) begin
                stable_d = syncOut;
                changed  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Sync flops come out of reset at the released level so a held button is not seen as a press.
    always_ff @(posedge clock or negedge resetButton) begin
        if (!resetButton) begin
            sync_q   <= {SYNC_DEPTH{RESET_VAL}};
            stable_q <= RESET_VAL;
            cnt_q    <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_DEPTH-2:0], rawIn};
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/run_stop_ctrl.sv
// Front-panel run/stop receiver: debounces the stop button and switch bank,
// and runs the run/halt state machine that gates the datapath.
// Optional feature macro: SINGLE_STEP_EN adds the STEP state (single
// instruction execution when the top switch is set on resume).
// Ports:
//   clock, resetButton      - clock and asynchronous active-low reset
//   stopButton              - raw active-low stop/resume button
//   switches[SW_WIDTH]      - raw switch inputs
//   haltReq, instrDone      - one-cycle pulses from the control unit
//   runOut, cpuEnable       - CPU executing / datapath clock enable
//   stopEvent               - one-cycle pulse per accepted stop press
//   inPortData, inPortValid - debounced switch snapshot and its settled flag
module run_stop_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned SW_WIDTH        = 8
) (
    input  logic                clock,
    input  logic                resetButton,
    input  logic                stopButton,
    input  logic [SW_WIDTH-1:0] switches,
    input  logic                haltReq,
    input  logic                instrDone,
    output logic                runOut,
    output logic                cpuEnable,
    output logic                stopEvent,
    output logic [SW_WIDTH-1:0] inPortData,
    output logic                inPortValid
);

    localparam int unsigned BOOT_CNT_W = $clog2(BOOT_CYCLES);

    logic                  stop_sync, stop_stable, stop_changed;
    logic [SW_WIDTH-1:0]   sw_sync, sw_stable;
    logic                  sw_changed;

    logic [STATE_W-1:0]    state_q, state_d;
    logic [BOOT_CNT_W-1:0] boot_cnt_q, boot_cnt_d;
    logic                  run_q, run_d;
    logic                  en_q, en_d;
    logic                  evt_q, evt_d;
    logic                  valid_q, valid_d;

    debounce #(
        .WIDTH     (1),
        .CYCLES    (DEBOUNCE_CYCLES),
        .RESET_VAL (1'b1)
    ) u_stop_db (
        .clock       (clock),
        .resetButton (resetButton),
        .rawIn       (stopButton),
        .syncOut     (stop_sync),
        .stableOut   (stop_stable),
        .changed     (stop_changed)
    );

    debounce #(
        .WIDTH     (SW_WIDTH),
        .CYCLES    (DEBOUNCE_CYCLES),
        .RESET_VAL ('0)
    ) u_sw_db (
        .clock       (clock),
        .resetButton (resetButton),
        .rawIn       (switches),
        .syncOut     (sw_sync),
        .stableOut   (sw_stable),
        .changed     (sw_changed)
    );

    // Press = accepted level leaving high for low; the release edge is ignored.
    assign evt_d   = stop_changed & stop_stable & ~stop_sync;
    // Snapshot is unsettled while the synchronized switches disagree with it.
    assign valid_d = sw_changed | (sw_sync == sw_stable);

    // Run/halt next-state logic; outputs follow the next state so they register with it.
    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        case (state_q)
            BOOT: begin
                if (boot_cnt_q == BOOT_CNT_W'(BOOT_CYCLES - 1)) begin
                    state_d = RUN;
                end else begin
                    boot_cnt_d = boot_cnt_q + BOOT_CNT_W'(1);
                end
            end
            RUN: begin
                if (haltReq) begin
                    state_d = HALTED;
                end else if (evt_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (haltReq || instrDone) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                if (evt_q) begin
`ifdef SINGLE_STEP_EN
                    state_d = sw_stable[SW_WIDTH-1] ? STEP : RUN;
`else
                    state_d = RUN;
`endif
                end
            end
`ifdef SINGLE_STEP_EN
            STEP: begin
                if (haltReq || instrDone) begin
                    state_d = HALTED;
                end
            end
`endif
            default: state_d = BOOT;
        endcase
        run_d = (state_d == RUN) || (state_d == DRAIN) || (state_d == STEP);
        en_d  = run_d;
    end

    always_ff @(posedge clock or negedge resetButton) begin
        if (!resetButton) begin
            state_q    <= BOOT;
            boot_cnt_q <= '0;
            run_q      <= 1'b0;
            en_q       <= 1'b0;
            evt_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            run_q      <= run_d;
            en_q       <= en_d;
            evt_q      <= evt_d;
            valid_q    <= valid_d;
        end
    end

    assign runOut      = run_q;
    assign cpuEnable   = en_q;
    assign stopEvent   = evt_q;
    assign inPortData  = sw_stable;
    assign inPortValid = valid_q;

endmodule

// File: tb/tb_run_stop_ctrl.sv
// Bench for run_stop_ctrl: table of {inputs, hold cycles, expected outputs}
// applied in a loop, plus a hand-written resume/step sequence.
module tb_run_stop_ctrl;

`ifdef SINGLE_STEP_EN
    localparam bit STEP_BUILD = 1'b1;
`else
    localparam bit STEP_BUILD = 1'b0;
`endif

    logic       clock;
    logic       resetButton;
    logic       stopButton;
    logic [7:0] switches;
    logic       haltReq;
    logic       instrDone;
    logic       runOut;
    logic       cpuEnable;
    logic       stopEvent;
    logic [7:0] inPortData;
    logic       inPortValid;

    run_stop_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .SW_WIDTH        (8)
    ) dut (
        .clock       (clock),
        .resetButton (resetButton),
        .stopButton  (stopButton),
        .switches    (switches),
        .haltReq     (haltReq),
        .instrDone   (instrDone),
        .runOut      (runOut),
        .cpuEnable   (cpuEnable),
        .stopEvent   (stopEvent),
        .inPortData  (inPortData),
        .inPortValid (inPortValid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst_n;
        logic        stop;
        logic [7:0]  sw;
        logic        halt;
        logic        done;
        int unsigned hold;
        logic        run;
        logic        en;
        logic        evt;
        logic [7:0]  data;
        logic        valid;
    } vec_t;

    typedef struct {
        logic       run;
        logic       en;
        logic       evt;
        logic [7:0] data;
        logic       valid;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp     = 0;
    int   n_bad     = 0;
    int   evt_seen  = 0;

    function automatic vec_t mk(input logic rst_n, input logic stop, input logic [7:0] sw,
                                input logic halt, input logic done, input int unsigned hold,
                                input logic run, input logic en, input logic evt,
                                input logic [7:0] data, input logic valid);
        vec_t v;
        v.rst_n = rst_n; v.stop = stop; v.sw = sw; v.halt = halt; v.done = done;
        v.hold = hold; v.run = run; v.en = en; v.evt = evt; v.data = data; v.valid = valid;
        return v;
    endfunction

    // Drive at a falling edge, let 'hold' rising edges pass, sample at the next falling edge.
    task automatic apply(input vec_t v, input string name);
        exp_t e;
        resetButton = v.rst_n;
        stopButton  = v.stop;
        switches    = v.sw;
        haltReq     = v.halt;
        instrDone   = v.done;
        e.run = v.run; e.en = v.en; e.evt = v.evt; e.data = v.data; e.valid = v.valid;
        sb.push_back(e);
        if (v.hold == 0) begin
            #1;
        end else begin
            repeat (v.hold) @(posedge clock);
            @(negedge clock);
        end
        e = sb.pop_front();
        n_cmp++;
        if (runOut !== e.run || cpuEnable !== e.en || stopEvent !== e.evt ||
            inPortData !== e.data || inPortValid !== e.valid) begin
            n_bad++;
            $display("FAIL %s: got run=%0b en=%0b evt=%0b data=%h valid=%0b, want run=%0b en=%0b evt=%0b data=%h valid=%0b",
                     name, runOut, cpuEnable, stopEvent, inPortData, inPortValid,
                     e.run, e.en, e.evt, e.data, e.valid);
        end
    endtask

    always @(negedge clock) begin
        if (stopEvent === 1'b1) evt_seen++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        resetButton = 1'b1;
        stopButton  = 1'b1;
        switches    = 8'h00;
        haltReq     = 1'b0;
        instrDone   = 1'b0;
        @(negedge clock);

        // Boot with the button held during reset, released shortly after.
        vecs.push_back(mk(0, 0, 8'h80, 0, 0, 2, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(1, 0, 8'h80, 0, 0, 1, 0, 0, 0, 8'h00, 1));
        vecs.push_back(mk(1, 1, 8'h80, 0, 0, 1, 1, 1, 0, 8'h00, 1));
        vecs.push_back(mk(1, 1, 8'h80, 0, 0, 1, 1, 1, 0, 8'h00, 0));
        vecs.push_back(mk(1, 1, 8'h80, 0, 0, 4, 1, 1, 0, 8'h80, 1));
        // Full press in RUN -> DRAIN, instrDone ends it.
        vecs.push_back(mk(1, 0, 8'h80, 0, 0, 5, 1, 1, 0, 8'h80, 1));
        vecs.push_back(mk(1, 0, 8'h80, 0, 0, 1, 1, 1, 1, 8'h80, 1));
        vecs.push_back(mk(1, 0, 8'h80, 0, 0, 1, 1, 1, 0, 8'h80, 1));
        vecs.push_back(mk(1, 0, 8'h80, 0, 0, 3, 1, 1, 0, 8'h80, 1));
        vecs.push_back(mk(1, 1, 8'h80, 0, 1, 1, 0, 0, 0, 8'h80, 1));
        vecs.push_back(mk(1, 1, 8'h80, 0, 0, 8, 0, 0, 0, 8'h80, 1));
        // Glitches of 3, 1 and 2 cycles in HALTED.
        vecs.push_back(mk(1, 0, 8'h80, 0, 0, 3, 0, 0, 0, 8'h80, 1));
        vecs.push_back(mk(1, 1, 8'h80, 0, 0, 2, 0, 0, 0, 8'h80, 1));
        vecs.push_back(mk(1, 0, 8'h80, 0, 0, 1, 0, 0, 0, 8'h80, 1));
        vecs.push_back(mk(1, 1, 8'h80, 0, 0, 6, 0, 0, 0, 8'h80, 1));
        vecs.push_back(mk(1, 0, 8'h80, 0, 0, 2, 0, 0, 0, 8'h80, 1));
        vecs.push_back(mk(1, 1, 8'h80, 0, 0, 6, 0, 0, 0, 8'h80, 1));
        // Resume press (RUN, or STEP when single-step is built in).
        vecs.push_back(mk(1, 0, 8'h80, 0, 0, 6, 0, 0, 1, 8'h80, 1));
        vecs.push_back(mk(1, 0, 8'h80, 0, 0, 1, 1, 1, 0, 8'h80, 1));
        vecs.push_back(mk(1, 1, 8'h80, 0, 0, 8, 1, 1, 0, 8'h80, 1));
        // haltReq coincident with stopEvent: straight to HALTED.
        vecs.push_back(mk(1, 0, 8'h80, 0, 0, 6, 1, 1, 1, 8'h80, 1));
        vecs.push_back(mk(1, 0, 8'h80, 1, 0, 1, 0, 0, 0, 8'h80, 1));
        vecs.push_back(mk(1, 1, 8'h80, 0, 0, 8, 0, 0, 0, 8'h80, 1));
        // Switch snapshot: 00 -> 5A, then a short FF bounce that is rejected.
        vecs.push_back(mk(1, 1, 8'h00, 0, 0, 8, 0, 0, 0, 8'h00, 1));
        vecs.push_back(mk(1, 1, 8'h5A, 0, 0, 2, 0, 0, 0, 8'h00, 1));
        vecs.push_back(mk(1, 1, 8'h5A, 0, 0, 1, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(1, 1, 8'h5A, 0, 0, 2, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(1, 1, 8'h5A, 0, 0, 1, 0, 0, 0, 8'h5A, 1));
        vecs.push_back(mk(1, 1, 8'hFF, 0, 0, 2, 0, 0, 0, 8'h5A, 1));
        vecs.push_back(mk(1, 1, 8'h5A, 0, 0, 1, 0, 0, 0, 8'h5A, 0));
        vecs.push_back(mk(1, 1, 8'h5A, 0, 0, 1, 0, 0, 0, 8'h5A, 0));
        vecs.push_back(mk(1, 1, 8'h5A, 0, 0, 1, 0, 0, 0, 8'h5A, 1));
        vecs.push_back(mk(1, 1, 8'h5A, 0, 0, 6, 0, 0, 0, 8'h5A, 1));
        // Resume, press again into DRAIN, then reset asynchronously.
        vecs.push_back(mk(1, 0, 8'h5A, 0, 0, 6, 0, 0, 1, 8'h5A, 1));
        vecs.push_back(mk(1, 0, 8'h5A, 0, 0, 1, 1, 1, 0, 8'h5A, 1));
        vecs.push_back(mk(1, 1, 8'h5A, 0, 0, 8, 1, 1, 0, 8'h5A, 1));
        vecs.push_back(mk(1, 0, 8'h5A, 0, 0, 6, 1, 1, 1, 8'h5A, 1));
        vecs.push_back(mk(1, 0, 8'h5A, 0, 0, 1, 1, 1, 0, 8'h5A, 1));
        vecs.push_back(mk(0, 0, 8'h5A, 0, 0, 0, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 0, 8'h5A, 0, 0, 2, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(1, 1, 8'h00, 0, 0, 1, 0, 0, 0, 8'h00, 1));
        vecs.push_back(mk(1, 1, 8'h00, 0, 0, 1, 1, 1, 0, 8'h00, 1));

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // Resume with the top switch set: STEP ends on instrDone, plain RUN ignores it.
        apply(mk(1, 1, 8'h00, 1, 0, 1, 0, 0, 0, 8'h00, 1), "step_halt");
        apply(mk(1, 1, 8'h80, 0, 0, 7, 0, 0, 0, 8'h80, 1), "step_sw");
        apply(mk(1, 0, 8'h80, 0, 0, 6, 0, 0, 1, 8'h80, 1), "step_press");
        apply(mk(1, 0, 8'h80, 0, 0, 1, 1, 1, 0, 8'h80, 1), "step_enter");
        apply(mk(1, 1, 8'h80, 0, 1, 1, !STEP_BUILD, !STEP_BUILD, 0, 8'h80, 1), "step_done");
        apply(mk(1, 1, 8'h80, 0, 0, 8, !STEP_BUILD, !STEP_BUILD, 0, 8'h80, 1), "step_after");

        n_cmp++;
        if (evt_seen != 6) begin
            n_bad++;
            $display("FAIL evt_count: got %0d stopEvent cycles, want 6", evt_seen);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/run_stop_ctrl.md
Name: run_stop_ctrl

Overview:
Front-panel receiver on the CPU side of the board/bench interface. It takes the raw active-low stopButton and the 8 switches, synchronizes and debounces them, and runs the run/halt state machine that gates the datapath (cpuEnable) and drives runOut. It also presents a stable switch snapshot to the IN-port logic. It sits between the top-level CPU pins and the control unit.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronized cycles required before a new level is accepted (small for simulation; raise for hardware)
SW_WIDTH, 8, switch bus width

Ports:
clock  in  1  system clock, all state on rising edge
resetButton  in  1  asynchronous active-low reset
stopButton  in  1  raw active-low stop/resume button
switches  in  SW_WIDTH  raw switch inputs
haltReq  in  1  control unit decoded HALT, one-cycle pulse
instrDone  in  1  control unit final T-state of the current instruction, one-cycle pulse
runOut  out  1  high while the CPU is executing
cpuEnable  out  1  datapath/control-unit clock enable
stopEvent  out  1  one-cycle pulse on each accepted stop press
inPortData  out  SW_WIDTH  debounced switch snapshot
inPortValid  out  1  high when inPortData is settled

Behaviour:
- Reset (resetButton=0, asynchronous): state=BOOT; runOut=0, cpuEnable=0, stopEvent=0, inPortData=0, inPortValid=0.
- Sync flops reset to the "released" value: stopButton=1, switches=0. A button held during reset is ignored.
- Sync: 2 flops per input bit. Input-to-debounced latency is 2 cycles + DEBOUNCE_CYCLES.
- Debounce: a per-channel counter increments while the synchronized value differs from the accepted value. It clears on any return to the accepted value. When it reaches DEBOUNCE_CYCLES, the accepted value updates and the counter clears.
- The switch bus is one channel: any bit change restarts its counter.
- stopEvent: pulses for one cycle on the accepted 1->0 transition of stop. Release generates nothing.
- inPortValid: drops the cycle after the synchronized switches differ from inPortData. It rises together with the inPortData update.
- FSM states:
  - BOOT: outputs low. Moves to RUN after 2 cycles.
  - RUN: runOut=1, cpuEnable=1.
  - DRAIN: runOut=1, cpuEnable=1.
  - HALTED: runOut=0, cpuEnable=0.
- Transitions, in priority order:
  - RUN: haltReq -> HALTED. Else stopEvent -> DRAIN.
  - DRAIN: haltReq or instrDone -> HALTED. stopEvent is ignored.
  - HALTED: stopEvent -> RUN. haltReq/instrDone are ignored.
- Outputs are registered, so the state change is visible the cycle after the triggering input.
- A haltReq arriving together with stopEvent in RUN gives HALTED with no DRAIN.
- A reset mid-instruction or mid-debounce returns to BOOT immediately. Counters clear.

Optional Feature:
SINGLE_STEP_EN
- Defined: adds state STEP (runOut=1, cpuEnable=1).
  - In HALTED, stopEvent with debounced switches[SW_WIDTH-1]=1 -> STEP. With that bit 0 -> RUN.
  - STEP: instrDone or haltReq -> HALTED.
- Undefined: STEP does not exist; HALTED+stopEvent always -> RUN.
- The state encoding width is unchanged either way.

Decomposition:
- Shared package run_ctrl_pkg holds:
  - the state localparams (BOOT, RUN, DRAIN, HALTED, STEP)
  - the state width (3)
  - the sync depth constant (2)
- Sub-module debounce (parameters WIDTH, CYCLES; ports clock, resetButton, rawIn, syncOut, stableOut, changed) is instantiated twice: WIDTH=1 for stop, WIDTH=SW_WIDTH for switches.
- The FSM, stopEvent edge detect and inPortValid logic live in run_stop_ctrl.

Test Plan:
1. resetButton=0 with stopButton=0 and switches=8'h80, then release resetButton, then stopButton=1 -> no stopEvent. runOut=0 for 2 cycles after reset release, then runOut=1, cpuEnable=1.
2. In RUN, stopButton low for 10 cycles; instrDone pulses 5 cycles after stopEvent -> stopEvent exactly once, 6 cycles after the press. State stays DRAIN (runOut=1) until the cycle after instrDone, then runOut=0, cpuEnable=0.
3. Stop press with glitches of 1-3 cycles (below DEBOUNCE_CYCLES=4) -> no stopEvent, state unchanged. A second full press in HALTED -> runOut=1.
4. In RUN, haltReq and stopEvent in the same cycle -> HALTED next cycle. DRAIN is never entered.
5. Switches 8'h00 -> 8'h5A -> inPortValid=0 from 3 cycles after the change. inPortData=8'h5A with inPortValid=1 at 6 cycles.
6. Assert resetButton while in DRAIN -> all outputs 0 asynchronously. SINGLE_STEP_EN build: HALTED, switches=8'h80, press -> STEP, then back to HALTED after one instrDone.
